imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Loader bus: program byte stream and start handshake in, instruction-memory write port and core hold out.
// The host/testbench side uses the master modport; the loader itself uses the slave modport.
interface imem_loader_if;
    logic        start;
    logic [15:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset_n;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, core_reset_n, busy, done, error
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, core_reset_n, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Streams little-endian program bytes into instruction memory while holding the core in reset.
// One word per 5 cycles at best (4 byte accepts + 1 write); byte_valid low stalls LOAD indefinitely.
module imem_loader #(
    parameter int IMEM_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);

    state_t      state;
    state_t      state_nxt;

    logic [15:0] count_q;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        error_q;

    logic        start_ok;
    logic        start_bad;
    logic        byte_acc;
    logic        last_byte;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        start_ok          = 1'b0;
        start_bad         = 1'b0;
        byte_acc          = 1'b0;
        last_byte         = 1'b0;
        bus.byte_ready    = 1'b0;
        bus.imem_we       = 1'b0;
        bus.busy          = 1'b1;
        bus.done          = 1'b0;
        bus.core_reset_n  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.busy         = 1'b0;
                bus.core_reset_n = reset;
                if (bus.start) begin
                    if (bus.word_count != 16'd0 && bus.word_count <= MAX_WORDS) begin
                        start_ok  = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                bus.byte_ready = 1'b1;
                byte_acc       = bus.byte_valid;
                last_byte      = byte_acc && (byte_idx == 2'd3);
                if (last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.imem_we = 1'b1;
                // word_idx still names the word being written; its successor decides completion
                state_nxt   = ((word_idx + 16'd1) == count_q) ? DONE : LOAD;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= 16'd0;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
            asm_q    <= 24'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            if (start_ok) begin
                count_q  <= bus.word_count;
                word_idx <= 16'd0;
                byte_idx <= 2'd0;
                error_q  <= 1'b0;
            end else if (start_bad) begin
                error_q  <= 1'b1;
            end

            if (byte_acc) begin
                byte_idx <= byte_idx + 2'd1;
                unique case (byte_idx)
                    2'd0:    asm_q[7:0]   <= bus.byte_data;
                    2'd1:    asm_q[15:8]  <= bus.byte_data;
                    2'd2:    asm_q[23:16] <= bus.byte_data;
                    default: ;
                endcase
            end

            // Output registers load only here, so they hold the last written word otherwise
            if (last_byte) begin
                addr_q  <= {14'd0, word_idx, 2'b00};
                wdata_q <= {bus.byte_data, asm_q};
            end

            if (state == WRITE) begin
                word_idx <= word_idx + 16'd1;
            end
        end
    end

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-level reference model fills a write scoreboard that a
// separate monitor drains on every imem_we; control outputs are checked around each load.
module tb_imem_loader;
    localparam int IMEM_WORDS = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    imem_loader_if bus();

    imem_loader #(.IMEM_WORDS(IMEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  stim_bytes[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          done_cnt  = 0;
    logic [31:0] last_addr = 32'd0;
    int          lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every memory write must match the next word the model predicted
    always @(negedge clk) begin
        if (reset && bus.done) done_cnt++;
        if (reset && bus.imem_we) begin
            last_addr = bus.imem_addr;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", bus.imem_addr, mon_e.addr);
                check("write_data", bus.imem_wdata, mon_e.data);
            end
        end
    end

    // Reference model: word w is bytes 4w..4w+3, little-endian, written at byte address 4w
    task automatic model_load(input int words);
        logic [31:0] d;
        for (int w = 0; w < words; w++) begin
            d = 32'(stim_bytes[4*w]) | (32'(stim_bytes[4*w+1]) << 8) |
                (32'(stim_bytes[4*w+2]) << 16) | (32'(stim_bytes[4*w+3]) << 24);
            exp_q.push_back({32'(4*w), d});
        end
    endtask

    task automatic fill_random(input int n);
        stim_bytes.delete();
        for (int i = 0; i < n; i++) stim_bytes.push_back(8'($urandom));
    endtask

    task automatic check_reset_vals(input string tag);
        check_bit({tag, "_byte_ready"}, bus.byte_ready, 1'b0);
        check_bit({tag, "_imem_we"}, bus.imem_we, 1'b0);
        check_bit({tag, "_busy"}, bus.busy, 1'b0);
        check_bit({tag, "_done"}, bus.done, 1'b0);
        check_bit({tag, "_error"}, bus.error, 1'b0);
        check_bit({tag, "_core_reset_n"}, bus.core_reset_n, 1'b0);
        check({tag, "_imem_addr"}, bus.imem_addr, 32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
    endtask

    // mode: 0 back-to-back, 1 valid toggling, 2 random valid, 3 random valid + start/word_count noise.
    // stop_after >= 0 asserts reset once that many bytes have been accepted.
    task automatic load(input int cnt, input int mode, input int stop_after, output int latency);
        int   total, idx, budget, acc_cyc, d0, w;
        logic v, tog;
        total   = (stop_after >= 0) ? stop_after : 4 * cnt;
        latency = -1;
        model_load(total / 4);
        d0 = done_cnt;

        @(negedge clk);
        bus.start      = 1'b1;
        bus.word_count = 16'(cnt);
        acc_cyc        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        check_bit("accept_busy", bus.busy, 1'b1);
        check_bit("accept_core_reset_n", bus.core_reset_n, 1'b0);
        check_bit("accept_error_clear", bus.error, 1'b0);

        idx = 0; budget = 0; tog = 1'b1;
        while (idx < total && budget < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            bus.byte_valid = v;
            bus.byte_data  = stim_bytes[idx];
            if (mode == 3) begin
                bus.start      = 1'($urandom_range(0, 1));
                bus.word_count = 16'($urandom_range(0, 100));
            end
            if (v && bus.byte_ready) idx++;
            budget++;
            if (idx < total) @(negedge clk);
        end
        if (idx < total) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_feed_timeout: %0d bytes accepted, expected %0d", idx, total);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;

        if (stop_after >= 0) begin
            reset = 1'b0;
            @(negedge clk);
            check_reset_vals("midload_reset");
            check("midload_pending_writes", 32'(exp_q.size()), 32'd0);
            reset = 1'b1;
            @(negedge clk);
            check_bit("post_reset_core_reset_n", bus.core_reset_n, 1'b1);
            return;
        end

        w = 0;
        while (!bus.done && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done not seen within %0d cycles", w);
        end else begin
            latency = cyc - acc_cyc;
            check_bit("done_core_reset_n", bus.core_reset_n, 1'b0);
            if (mode == 0) check("done_latency", 32'(latency), 32'(5 * cnt + 1));
        end
        @(negedge clk);
        check_bit("after_done_pulse", bus.done, 1'b0);
        check_bit("after_done_core_reset_n", bus.core_reset_n, 1'b1);
        check_bit("after_done_busy", bus.busy, 1'b0);
        check("done_pulse_count", 32'(done_cnt - d0), 32'd1);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic issue_bad(input int wc);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.word_count = 16'(wc);
        @(negedge clk);
        bus.start = 1'b0;
        check_bit("bad_start_error", bus.error, 1'b1);
        check_bit("bad_start_busy", bus.busy, 1'b0);
        check_bit("bad_start_core_reset_n", bus.core_reset_n, 1'b1);
        repeat (3) @(negedge clk);
        check_bit("bad_start_error_sticky", bus.error, 1'b1);
        check_bit("bad_start_byte_ready", bus.byte_ready, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, mode;
        bus.start      = 1'b0;
        bus.word_count = 16'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        reset          = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);
        check_bit("idle_core_reset_n", bus.core_reset_n, 1'b1);
        check_bit("idle_busy", bus.busy, 1'b0);

        // Two instructions streamed back-to-back
        stim_bytes = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load(2, 0, -1, lat);
        check("hold_addr", bus.imem_addr, 32'h0000_0004);
        check("hold_wdata", bus.imem_wdata, 32'h0010_0093);

        // Valid toggling every cycle
        stim_bytes = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load(1, 1, -1, lat);
        check("toggle_addr", bus.imem_addr, 32'h0000_0000);
        check("toggle_wdata", bus.imem_wdata, 32'hDEAD_BEEF);

        // Rejected starts, then an accepted start clears the flag
        issue_bad(0);
        issue_bad(IMEM_WORDS + 1);
        fill_random(4);
        load(1, 2, -1, lat);

        // Full-capacity load
        fill_random(4 * IMEM_WORDS);
        load(IMEM_WORDS, 2, -1, lat);
        check("full_last_addr", last_addr, 32'h0000_00FC);

        // Reset after two bytes of word 1, then reload from address 0
        fill_random(6);
        load(3, 0, 6, lat);
        fill_random(8);
        load(2, 0, -1, lat);
        check("reload_last_addr", last_addr, 32'h0000_0004);

        // start and word_count noise during the load
        fill_random(16);
        load(4, 3, -1, lat);

        repeat (6) begin
            cnt  = $urandom_range(1, 6);
            mode = $urandom_range(0, 3);
            fill_random(4 * cnt);
            load(cnt, mode, -1, lat);
        end

        fill_random(10);
        load(5, 2, 10, lat);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
